// File: rtl/sc_mac_array.sv
// ----------------------------------------------------------------------------
// sc_mac_array
// Deterministic stochastic-computing multiply-accumulate over NUM_CH operand
// pairs. Each operand is turned into a unary bit stream by comparing it with a
// counter. X is compared with the low half of the counter and Y with the high
// half (clock-division pairing), so an AND of the two streams holds exactly
// x*y ones over L = 2**(2*WIDTH) cycles. The channel products are then summed.
// ADD_MODE=0 sums them exactly with a per-cycle popcount. ADD_MODE=1 picks one
// channel per cycle through an LFSR-driven MUX, which scales the sum by
// 1/NUM_CH. The summed stream is counted back to binary.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-low reset
//   start    in   run request, sampled only while idle
//   x_bn     in   NUM_CH packed X operands, channel i at [i*WIDTH +: WIDTH]
//   y_bn     in   NUM_CH packed Y operands, same packing
//   busy     out  high from start acceptance until done
//   done     out  one-cycle pulse, result valid
//   result   out  binary count of the summed stream, held until next start
//   q_sn     out  summed stream bit (ADD_MODE=1), else 0
//   q_valid  out  q_sn qualifier (ADD_MODE=1), else 0
// ----------------------------------------------------------------------------
module sc_mac_array #(
   parameter int WIDTH    = 7,
   parameter int NUM_CH   = 4,
   parameter int ADD_MODE = 0,
   parameter int SEED     = 35
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [NUM_CH*WIDTH-1:0]              x_bn,
   input  logic [NUM_CH*WIDTH-1:0]              y_bn,
   output logic                                 busy,
   output logic                                 done,
   output logic [2*WIDTH+$clog2(NUM_CH)-1:0]    result,
   output logic                                 q_sn,
   output logic                                 q_valid
);

   localparam int CNT_W = 2 * WIDTH;
   localparam int SEL_W = $clog2(NUM_CH);
   localparam int PC_W  = SEL_W + 1;            // popcount of NUM_CH bits
   localparam int ACC_W = 2 * WIDTH + SEL_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                      state_reg;
   logic [CNT_W-1:0]            cnt_reg;
   logic                        drain_reg;
   logic [NUM_CH*WIDTH-1:0]     x_reg, y_reg;
   logic [NUM_CH-1:0]           p_reg, p_next;
   logic                        v1_reg;
   logic                        busy_reg, done_reg;
   logic [ACC_W-1:0]            result_reg;
   logic                        q_sn_reg, q_valid_reg;
   logic                        q_sn_next, q_valid_next;
   logic [PC_W-1:0]             add_next;

   wire start_acc = (state_reg == S_IDLE) && start;
   wire in_run    = (state_reg == S_RUN);

   // Stream generators: X against cnt_lo, Y against cnt_hi.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_sng
         wire sx = x_reg[gi*WIDTH +: WIDTH] > cnt_reg[WIDTH-1:0];
         wire sy = y_reg[gi*WIDTH +: WIDTH] > cnt_reg[CNT_W-1:WIDTH];
         assign p_next[gi] = sx & sy;
      end
   endgenerate

   generate
      if (ADD_MODE == 0) begin : g_exact
         always_comb begin
            add_next = '0;
            for (int i = 0; i < NUM_CH; i++)
               add_next = add_next + PC_W'(p_reg[i]);
         end
         assign q_sn_next    = 1'b0;
         assign q_valid_next = 1'b0;
      end else begin : g_scaled
         // Fibonacci LFSR, shift left; tap n sits at bit n-1.
         localparam logic [7:0] TAPS =
            (WIDTH == 3) ? 8'h06 : (WIDTH == 4) ? 8'h0C :
            (WIDTH == 5) ? 8'h14 : (WIDTH == 6) ? 8'h30 :
            (WIDTH == 7) ? 8'h60 : 8'hB8;
         logic [WIDTH-1:0] lfsr_reg;
         logic [SEL_W-1:0] sel_reg;
         wire fb = ^(lfsr_reg & TAPS[WIDTH-1:0]);

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               lfsr_reg <= WIDTH'(SEED);
               sel_reg  <= '0;
            end else if (start_acc) begin
               lfsr_reg <= WIDTH'(SEED);
            end else if (in_run) begin
               // sel travels with the product registered on the same edge
               sel_reg  <= lfsr_reg[WIDTH-1 -: SEL_W];
               lfsr_reg <= {lfsr_reg[WIDTH-2:0], fb};
            end
         end

         assign q_sn_next    = v1_reg & p_reg[sel_reg];
         assign q_valid_next = v1_reg;
         assign add_next     = PC_W'(q_sn_next);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         drain_reg   <= 1'b0;
         x_reg       <= '0;
         y_reg       <= '0;
         p_reg       <= '0;
         v1_reg      <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         result_reg  <= '0;
         q_sn_reg    <= 1'b0;
         q_valid_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         // stage 1: product register, zero outside RUN so stage 2 idles
         p_reg  <= in_run ? p_next : '0;
         v1_reg <= in_run;

         // stage 2: accumulate summed stream
         q_sn_reg    <= q_sn_next;
         q_valid_reg <= q_valid_next;
         if (v1_reg)
            result_reg <= result_reg + ACC_W'(add_next);

         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  x_reg      <= x_bn;
                  y_reg      <= y_bn;
                  cnt_reg    <= '0;
                  result_reg <= '0;
                  busy_reg   <= 1'b1;
                  state_reg  <= S_RUN;
               end
            end
            S_RUN: begin
               if (cnt_reg == {CNT_W{1'b1}}) begin
                  drain_reg <= 1'b0;
                  state_reg <= S_DRAIN;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_DRAIN: begin
               // two cycles: lets stage 1 and stage 2 empty
               drain_reg <= 1'b1;
               if (drain_reg)
                  state_reg <= S_DONE;
            end
            S_DONE: begin
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign result  = result_reg;
   assign q_sn    = q_sn_reg;
   assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_sc_mac_array.sv
// ----------------------------------------------------------------------------
// tb_sc_mac_array
// Directed bench for sc_mac_array. Three instances share the clock and reset:
//   [0] WIDTH=3, NUM_CH=4, exact add
//   [1] WIDTH=3, NUM_CH=2, scaled add, SEED=5
//   [2] WIDTH=7, NUM_CH=4, exact add
// Expected values are hand-computed sums of x_i*y_i (the scaled-add count of
// 24 follows from stepping the 3-bit LFSR 5,3,7,6,4,1,2 over the 64 cycles).
// ----------------------------------------------------------------------------
module tb_sc_mac_array;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  start_v = '0;
   logic [2:0]  busy_v, done_v, qsn_v, qv_v;
   logic [11:0] x0, y0;
   logic [5:0]  x1, y1;
   logic [27:0] x2, y2;
   logic [7:0]  res0;
   logic [6:0]  res1;
   logic [15:0] res2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sc_mac_array #(.WIDTH(3), .NUM_CH(4), .ADD_MODE(0), .SEED(35)) u_w3m0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .x_bn(x0), .y_bn(y0),
      .busy(busy_v[0]), .done(done_v[0]), .result(res0),
      .q_sn(qsn_v[0]), .q_valid(qv_v[0]));

   sc_mac_array #(.WIDTH(3), .NUM_CH(2), .ADD_MODE(1), .SEED(5)) u_w3m1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .x_bn(x1), .y_bn(y1),
      .busy(busy_v[1]), .done(done_v[1]), .result(res1),
      .q_sn(qsn_v[1]), .q_valid(qv_v[1]));

   sc_mac_array #(.WIDTH(7), .NUM_CH(4), .ADD_MODE(0), .SEED(35)) u_w7m0 (
      .clk(clk), .rst(rst), .start(start_v[2]), .x_bn(x2), .y_bn(y2),
      .busy(busy_v[2]), .done(done_v[2]), .result(res2),
      .q_sn(qsn_v[2]), .q_valid(qv_v[2]));

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Start one run on instance 'which' and follow it until done (or limit).
   // lat = edges from acceptance edge to the edge that raises done.
   // pa/pb: lat values at which an extra start pulse is injected.
   task automatic run_dut(input int which, input bit hold, input int pa, input int pb,
                          input int limit, output int lat, output int busy_n,
                          output int qv_n, output int q1_n);
      @(negedge clk);
      start_v[which] = 1'b1;
      @(posedge clk);
      #1;
      lat = 0; busy_n = 0; qv_n = 0; q1_n = 0;
      while (1) begin
         start_v[which] = hold || (lat == pa) || (lat == pb);
         if (lat == 5 && which == 0) begin
            x0 = ~x0;                       // operands must already be latched
            y0 = ~y0;
         end
         if (busy_v[which]) busy_n++;
         if (qv_v[which])   qv_n++;
         if (qsn_v[which])  q1_n++;
         if (done_v[which] || lat >= limit) break;
         @(posedge clk);
         #1;
         lat++;
      end
      start_v[which] = hold;
   endtask

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      int          exp;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int lat, bn, qn, q1, dn;

      vecs[0] = '{12'h005, 12'h003, 15};
      vecs[1] = '{12'hFFF, 12'hFFF, 196};
      vecs[2] = '{{3'd1, 3'd2, 3'd3, 3'd4}, {3'd7, 3'd6, 3'd5, 3'd4}, 50};
      vecs[3] = '{{3'd6, 3'd2, 3'd0, 3'd7}, {3'd1, 3'd3, 3'd7, 3'd0}, 12};
      vecs[4] = '{{3'd7, 3'd1, 3'd0, 3'd5}, {3'd1, 3'd7, 3'd3, 3'd5}, 39};

      x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy",    busy_v, 0);
      check_eq("rst_done",    done_v, 0);
      check_eq("rst_qsn",     qsn_v,  0);
      check_eq("rst_qvalid",  qv_v,   0);
      check_eq("rst_results", res0 + res1 + res2, 0);
      @(negedge clk);
      rst = 1'b1;

      // exact add, directed vectors
      foreach (vecs[i]) begin
         x0 = vecs[i].x;
         y0 = vecs[i].y;
         run_dut(0, 1'b0, -1, -1, 200, lat, bn, qn, q1);
         $display("w3m0 vec%0d: result=%0d latency=%0d busy=%0d", i, res0, lat, bn);
         check_eq($sformatf("w3m0_res%0d", i), res0, vecs[i].exp);
         check_eq($sformatf("w3m0_lat%0d", i), lat, 67);
         check_eq($sformatf("w3m0_busy%0d", i), bn, 67);
         check_eq($sformatf("w3m0_qvalid%0d", i), qn + q1, 0);
      end

      // extra start pulses in RUN and in the DONE cycle are ignored
      x0 = vecs[2].x; y0 = vecs[2].y;
      run_dut(0, 1'b0, 10, 66, 200, lat, bn, qn, q1);
      $display("w3m0 pulsed: result=%0d latency=%0d", res0, lat);
      check_eq("pulse_res", res0, 50);
      check_eq("pulse_lat", lat, 67);
      bn = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (busy_v[0] || done_v[0]) bn++;
      end
      check_eq("pulse_no_restart", bn, 0);

      // start held high: back-to-back runs, one done each
      x0 = vecs[0].x; y0 = vecs[0].y;
      run_dut(0, 1'b1, -1, -1, 200, lat, bn, qn, q1);
      $display("w3m0 b2b run1: result=%0d latency=%0d", res0, lat);
      check_eq("b2b1_res", res0, 15);
      check_eq("b2b1_lat", lat, 67);
      x0 = vecs[4].x; y0 = vecs[4].y;
      run_dut(0, 1'b0, -1, -1, 200, lat, bn, qn, q1);
      $display("w3m0 b2b run2: result=%0d latency=%0d", res0, lat);
      check_eq("b2b2_res", res0, 39);
      check_eq("b2b2_lat", lat, 67);
      check_eq("b2b2_busy", bn, 67);

      // scaled add
      x1 = {3'd4, 3'd7}; y1 = {3'd2, 3'd6};
      run_dut(1, 1'b0, -1, -1, 200, lat, bn, qn, q1);
      $display("w3m1 run: result=%0d latency=%0d qvalid=%0d ones=%0d", res1, lat, qn, q1);
      check_eq("m1_res",    res1, 24);
      check_eq("m1_qvalid", qn, 64);
      check_eq("m1_ones",   q1, 24);
      check_eq("m1_lat",    lat, 67);

      // reset in the middle of a run
      @(negedge clk);
      start_v[1] = 1'b1;
      @(posedge clk);
      #1;
      start_v[1] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_eq("abort_busy",   busy_v[1], 0);
      check_eq("abort_qvalid", qv_v[1], 0);
      check_eq("abort_qsn",    qsn_v[1], 0);
      check_eq("abort_res",    res1, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      dn = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (done_v[1] || busy_v[1]) dn++;
      end
      $display("w3m1 aborted: activity after reset=%0d", dn);
      check_eq("abort_no_done", dn, 0);
      run_dut(1, 1'b0, -1, -1, 200, lat, bn, qn, q1);
      $display("w3m1 rerun: result=%0d latency=%0d qvalid=%0d", res1, lat, qn);
      check_eq("rerun_res",    res1, 24);
      check_eq("rerun_qvalid", qn, 64);

      // full-scale WIDTH=7
      x2 = {4{7'd127}}; y2 = {4{7'd127}};
      run_dut(2, 1'b0, -1, -1, 20000, lat, bn, qn, q1);
      $display("w7m0 run: result=%0d latency=%0d", res2, lat);
      check_eq("w7_res",  res2, 64516);
      check_eq("w7_lat",  lat, 16387);
      check_eq("w7_busy", bn, 16387);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
